// File: rtl/ff_rd_sched_pkg.sv
// Shared types and helpers for the FIFO read scheduler and sibling arbiters.
package ff_rd_sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Widest request vector the round-robin helper accepts.
    localparam int RR_MAX = 32;

    // Round-robin search: first set bit of req[n-1:0] starting at last+1,
    // wrapping modulo n. Returns -1 when no request is set.
    function automatic int rr_next(input logic [RR_MAX-1:0] req,
                                   input int n,
                                   input int last);
        int idx;
        rr_next = -1;
        for (int k = 1; k <= RR_MAX; k++) begin
            if (k <= n) begin
                idx = (last + k) % n;
                if (req[idx] && rr_next < 0) rr_next = idx;
            end
        end
    endfunction

endpackage

// File: rtl/ff_rd_sched_rr_arb.sv
// Combinational round-robin picker: lowest-distance requester after 'last'.
module rr_arb
    import ff_rd_sched_pkg::*;
#(
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] last,
    output logic [SEL_W-1:0] gnt,
    output logic             vld
);

    logic [RR_MAX-1:0] req_w;
    int                pick;

    // Widen the request vector to the helper's width and search from last+1.
    always_comb begin
        req_w        = '0;
        req_w[N-1:0] = req;
        pick         = rr_next(req_w, N, int'(last));
        vld          = (pick >= 0);
        gnt          = vld ? SEL_W'(pick) : '0;
    end

endmodule

// File: rtl/ff_rd_sched.sv
// Round-robin burst read scheduler draining several FIFOs into one sink,
// with read-latency-aligned source/sop/eop tagging of returning data.
module ff_rd_sched
    import ff_rd_sched_pkg::*;
#(
    parameter int NUM_INTFS = 4,
    parameter int FF_DEPTH  = 16,
    parameter int MAX_BURST = 4,
    parameter int RD_LAT    = 1,
    parameter int SEL_W     = $clog2(NUM_INTFS),
    parameter int OCC_W     = $clog2(FF_DEPTH) + 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            sched_en,
    input  logic [NUM_INTFS-1:0]            ff_empty,
    input  logic [NUM_INTFS-1:0][OCC_W-1:0] ff_occ,
    input  logic                            sink_rdy,
    output logic [NUM_INTFS-1:0]            ff_rd_en,
    output logic [SEL_W-1:0]                rd_sel,
    output logic                            data_vld,
    output logic [SEL_W-1:0]                data_sel,
    output logic                            data_sop,
    output logic                            data_eop,
    output logic                            busy
);

    localparam int BC_W = $clog2(MAX_BURST) + 1;

    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic             sop;
        logic             eop;
    } tag_t;

    state_t           state, state_nxt;
    logic [SEL_W-1:0] gnt, gnt_nxt;
    logic [SEL_W-1:0] last_gnt, last_gnt_nxt;
    logic [BC_W-1:0]  burst_cnt, burst_cnt_nxt;
    logic [SEL_W-1:0] arb_gnt;
    logic             arb_vld;
    logic             rd_issue, rd_last;

    // Stage 0 is the read issued this cycle; stages 1..RD_LAT are registered.
    logic             vld_in;
    tag_t             tag_in;
    logic [RD_LAT:1]  vld_pipe;
    tag_t             tag_pipe [1:RD_LAT];

    rr_arb #(.N(NUM_INTFS), .SEL_W(SEL_W)) u_arb (
        .req  (~ff_empty),
        .last (last_gnt),
        .gnt  (arb_gnt),
        .vld  (arb_vld)
    );

    // FSM state, grant, priority pointer and burst counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            last_gnt  <= SEL_W'(NUM_INTFS - 1);
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            gnt       <= gnt_nxt;
            last_gnt  <= last_gnt_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

    // Next-state: grant in IDLE, issue reads in BURST until the burst ends.
    always_comb begin
        state_nxt     = state;
        gnt_nxt       = gnt;
        last_gnt_nxt  = last_gnt;
        burst_cnt_nxt = burst_cnt;
        rd_issue      = 1'b0;
        rd_last       = 1'b0;
        ff_rd_en      = '0;
        case (state)
            IDLE: begin
                if (sched_en && arb_vld) begin
                    state_nxt     = BURST;
                    gnt_nxt       = arb_gnt;
                    burst_cnt_nxt = '0;
                end
            end
            BURST: begin
                // Empty under grant only happens with inexact occupancy; bail
                // out quietly without an eop.
                if (ff_empty[gnt]) begin
                    state_nxt = IDLE;
                end else if (sink_rdy) begin
                    rd_issue      = 1'b1;
                    ff_rd_en[gnt] = 1'b1;
                    burst_cnt_nxt = burst_cnt + 1'b1;
                    if (burst_cnt == BC_W'(MAX_BURST - 1) || ff_occ[gnt] == OCC_W'(1)) begin
                        rd_last      = 1'b1;
                        last_gnt_nxt = gnt;
                        state_nxt    = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Tag for the word being read this cycle; zero when nothing is issued.
    always_comb begin
        vld_in     = rd_issue;
        tag_in     = '0;
        tag_in.sel = rd_issue ? gnt : '0;
        tag_in.sop = rd_issue && (burst_cnt == '0);
        tag_in.eop = rd_last;
    end

    // Delay valid and tag by the memory read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            for (int i = 1; i <= RD_LAT; i++) tag_pipe[i] <= '0;
        end else begin
            vld_pipe[1] <= vld_in;
            tag_pipe[1] <= tag_in;
            for (int i = 2; i <= RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign rd_sel   = gnt;
    assign data_vld = vld_pipe[RD_LAT];
    assign data_sel = tag_pipe[RD_LAT].sel;
    assign data_sop = tag_pipe[RD_LAT].sop;
    assign data_eop = tag_pipe[RD_LAT].eop;
    assign busy     = (state != IDLE) || (|vld_pipe);

endmodule

// File: tb/tb_ff_rd_sched.sv
// Directed bench for ff_rd_sched: vector table plus round-robin and reset sequences.
module tb_ff_rd_sched;

    localparam int N     = 4;
    localparam int DEPTH = 16;
    localparam int MB    = 4;
    localparam int SEL_W = 2;
    localparam int OCC_W = 5;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    sched_en;
    logic                    sink_rdy;
    logic [N-1:0]            ff_empty;
    logic [N-1:0][OCC_W-1:0] ff_occ;

    logic [N-1:0]     a_rd_en, b_rd_en;
    logic [SEL_W-1:0] a_rd_sel, b_rd_sel, a_sel, b_sel;
    logic             a_vld, a_sop, a_eop, a_busy;
    logic             b_vld, b_sop, b_eop, b_busy;

    int occ [N];
    int total = 0;
    int bad   = 0;

    typedef struct {
        int           set_idx;
        int           set_val;
        logic         rdy;
        logic         en;
        logic [N-1:0] rd;
        logic         vld;
        int           sel;
        logic         sop;
        logic         eop;
        logic         busy;
    } vec_t;

    vec_t q [$];

    always #5 clk = ~clk;

    // FIFO occupancy model driven from the bench's counters.
    always_comb begin
        ff_empty = '0;
        ff_occ   = '0;
        for (int i = 0; i < N; i++) begin
            ff_empty[i] = (occ[i] == 0);
            ff_occ[i]   = OCC_W'(occ[i]);
        end
    end

    ff_rd_sched #(.NUM_INTFS(N), .FF_DEPTH(DEPTH), .MAX_BURST(MB), .RD_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .sched_en(sched_en), .ff_empty(ff_empty),
        .ff_occ(ff_occ), .sink_rdy(sink_rdy), .ff_rd_en(a_rd_en), .rd_sel(a_rd_sel),
        .data_vld(a_vld), .data_sel(a_sel), .data_sop(a_sop), .data_eop(a_eop),
        .busy(a_busy)
    );

    ff_rd_sched #(.NUM_INTFS(N), .FF_DEPTH(DEPTH), .MAX_BURST(MB), .RD_LAT(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .sched_en(sched_en), .ff_empty(ff_empty),
        .ff_occ(ff_occ), .sink_rdy(sink_rdy), .ff_rd_en(b_rd_en), .rd_sel(b_rd_sel),
        .data_vld(b_vld), .data_sel(b_sel), .data_sop(b_sop), .data_eop(b_eop),
        .busy(b_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Advance one clock; FIFOs lose the words read in the cycle just ended.
    task automatic tick();
        logic [N-1:0] rd;
        rd = a_rd_en;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (rd[i]) occ[i]--;
    endtask

    task automatic add(input int si, input int sv, input logic rdy, input logic en,
                       input logic [N-1:0] rd, input logic vld, input int sel,
                       input logic sop, input logic eop, input logic bsy);
        vec_t v;
        v = '{si, sv, rdy, en, rd, vld, sel, sop, eop, bsy};
        q.push_back(v);
    endtask

    int got [$];
    int nvld;

    initial begin
        rst_n    = 1'b0;
        sched_en = 1'b0;
        sink_rdy = 1'b0;
        for (int i = 0; i < N; i++) occ[i] = 0;

        // Reset state.
        #12;
        chk("rst rd_en", a_rd_en, 0);
        chk("rst rd_sel", a_rd_sel, 0);
        chk("rst vld", a_vld, 0);
        chk("rst busy", a_busy, 0);
        chk("rst b_busy", b_busy, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // All FIFOs empty: nothing ever issued.
        sched_en = 1'b1;
        sink_rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk($sformatf("empty%0d rd_en", k), a_rd_en, 0);
            chk($sformatf("empty%0d busy", k), a_busy, 0);
            tick();
        end

        // FIFO 2 with 10 words: bursts 4,4,2 with one idle cycle between.
        add(2, 10, 1, 1, 4'b0000, 0, 0, 0, 0, 0);
        add(-1, 0, 1, 1, 4'b0100, 0, 0, 0, 0, 1);
        add(-1, 0, 1, 1, 4'b0100, 1, 2, 1, 0, 1);
        add(-1, 0, 1, 1, 4'b0100, 1, 2, 0, 0, 1);
        add(-1, 0, 1, 1, 4'b0100, 1, 2, 0, 0, 1);
        add(-1, 0, 1, 1, 4'b0000, 1, 2, 0, 1, 1);
        add(-1, 0, 1, 1, 4'b0100, 0, 0, 0, 0, 1);
        add(-1, 0, 1, 1, 4'b0100, 1, 2, 1, 0, 1);
        add(-1, 0, 1, 1, 4'b0100, 1, 2, 0, 0, 1);
        add(-1, 0, 1, 1, 4'b0100, 1, 2, 0, 0, 1);
        add(-1, 0, 1, 1, 4'b0000, 1, 2, 0, 1, 1);
        add(-1, 0, 1, 1, 4'b0100, 0, 0, 0, 0, 1);
        add(-1, 0, 1, 1, 4'b0100, 1, 2, 1, 0, 1);
        add(-1, 0, 1, 1, 4'b0000, 1, 2, 0, 1, 1);
        add(-1, 0, 1, 1, 4'b0000, 0, 0, 0, 0, 0);
        // FIFO 1 with 4 words, sink_rdy 1,0,0,1,1,1 over the burst.
        add(1, 4, 1, 1, 4'b0000, 0, 0, 0, 0, 0);
        add(-1, 0, 1, 1, 4'b0010, 0, 0, 0, 0, 1);
        add(-1, 0, 0, 1, 4'b0000, 1, 1, 1, 0, 1);
        add(-1, 0, 0, 1, 4'b0000, 0, 0, 0, 0, 1);
        add(-1, 0, 1, 1, 4'b0010, 0, 0, 0, 0, 1);
        add(-1, 0, 1, 1, 4'b0010, 1, 1, 0, 0, 1);
        add(-1, 0, 1, 1, 4'b0010, 1, 1, 0, 0, 1);
        add(-1, 0, 1, 1, 4'b0000, 1, 1, 0, 1, 1);
        add(-1, 0, 1, 1, 4'b0000, 0, 0, 0, 0, 0);
        // FIFO 0 with 6 words; sched_en drops on the 2nd word.
        add(0, 6, 1, 1, 4'b0000, 0, 0, 0, 0, 0);
        add(-1, 0, 1, 1, 4'b0001, 0, 0, 0, 0, 1);
        add(-1, 0, 1, 0, 4'b0001, 1, 0, 1, 0, 1);
        add(-1, 0, 1, 0, 4'b0001, 1, 0, 0, 0, 1);
        add(-1, 0, 1, 0, 4'b0001, 1, 0, 0, 0, 1);
        add(-1, 0, 1, 0, 4'b0000, 1, 0, 0, 1, 1);
        add(-1, 0, 1, 0, 4'b0000, 0, 0, 0, 0, 0);
        add(-1, 0, 1, 0, 4'b0000, 0, 0, 0, 0, 0);

        foreach (q[k]) begin
            if (q[k].set_idx >= 0) occ[q[k].set_idx] = q[k].set_val;
            sink_rdy = q[k].rdy;
            sched_en = q[k].en;
            #1;
            chk($sformatf("v%0d rd_en", k), a_rd_en, q[k].rd);
            chk($sformatf("v%0d vld", k), a_vld, q[k].vld);
            chk($sformatf("v%0d busy", k), a_busy, q[k].busy);
            if (q[k].rd != 0) chk($sformatf("v%0d rd_sel", k), a_rd_sel, $clog2(q[k].rd));
            if (q[k].vld) begin
                chk($sformatf("v%0d sel", k), a_sel, q[k].sel);
                chk($sformatf("v%0d sop", k), a_sop, q[k].sop);
                chk($sformatf("v%0d eop", k), a_eop, q[k].eop);
            end
            tick();
        end

        // Round-robin order from reset: one word in each FIFO.
        for (int i = 0; i < N; i++) occ[i] = 0;
        rst_n = 1'b0;
        #1;
        chk("rr rst rd_en", a_rd_en, 0);
        chk("rr rst busy", a_busy, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) occ[i] = 1;
        sched_en = 1'b1;
        sink_rdy = 1'b1;
        nvld = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            for (int i = 0; i < N; i++) if (a_rd_en[i]) got.push_back(i);
            if (a_vld) begin
                nvld++;
                chk($sformatf("rr c%0d sop", c), a_sop, 1);
                chk($sformatf("rr c%0d eop", c), a_eop, 1);
            end
            tick();
        end
        chk("rr nvld", nvld, 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("rr order%0d", i), (i < got.size()) ? got[i] : -1, i);

        // Refill 0 and 3 after last grant 3: wrap gives 0 first, then 3.
        got.delete();
        occ[0] = 1;
        occ[3] = 1;
        for (int c = 0; c < 6; c++) begin
            #1;
            for (int i = 0; i < N; i++) if (a_rd_en[i]) got.push_back(i);
            tick();
        end
        chk("wrap count", got.size(), 2);
        chk("wrap first", (got.size() > 0) ? got[0] : -1, 0);
        chk("wrap second", (got.size() > 1) ? got[1] : -1, 3);

        // Reset with two reads in flight in the RD_LAT=3 instance.
        occ[1] = 4;
        for (int c = 0; c < 3; c++) begin
            #1;
            tick();
        end
        #1;
        chk("inflight b_busy", b_busy, 1);
        chk("inflight b_vld", b_vld, 0);
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) occ[i] = 0;
        #1;
        chk("mid rst b_vld", b_vld, 0);
        chk("mid rst b_busy", b_busy, 0);
        chk("mid rst b_rd_en", b_rd_en, 0);
        chk("mid rst b_rd_sel", b_rd_sel, 0);
        chk("mid rst a_vld", a_vld, 0);
        chk("mid rst a_busy", a_busy, 0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("post rst%0d b_vld", c), b_vld, 0);
            chk($sformatf("post rst%0d b_busy", c), b_busy, 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
